// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_hazard_ctrl_pkg;

   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_WAIT = 2'd1,
      DIV_DONE = 2'd2
   } div_state_t;

   // True when an ID source operand is actually read and names the given register.
   function automatic logic src_hit(input logic use_src,
                                    input logic [REG_W-1:0] src,
                                    input logic [REG_W-1:0] dest);
      return use_src && (src == dest);
   endfunction

endpackage

// File: rtl/pipe_div_seq.sv
// rtl/pipe_div_seq.sv - EX-stage divider sequencer: start/wait/done FSM with saturating cycle counter
module pipe_div_seq
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int DIV_MAX_CYC = 40,
   parameter int CNT_W       = 6
) (
   input  logic clk,
   input  logic reset,
   input  logic start_req,
   input  logic div_done,
   input  logic abort,
   output logic div_start,
   output logic div_busy,
   output logic div_stall,
   output logic div_timeout
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_MAX_CYC);

   div_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic             start_q;
   logic             timeout_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= DIV_IDLE;
         cnt       <= '0;
         start_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         start_q <= 1'b0;
         if (abort) begin
            // A flush wins over everything, including a div trying to start.
            state <= DIV_IDLE;
            cnt   <= '0;
         end else begin
            case (state)
               DIV_IDLE: begin
                  if (start_req) begin
                     state   <= DIV_WAIT;
                     cnt     <= '0;
                     start_q <= 1'b1;
                  end
               end
               DIV_WAIT: begin
                  if (cnt != CNT_MAX)
                     cnt <= cnt + 1'b1;
                  if (cnt >= CNT_MAX - 1'b1)
                     timeout_q <= 1'b1;
                  if (div_done)
                     state <= DIV_DONE;
               end
               DIV_DONE: state <= DIV_IDLE;
               default:  state <= DIV_IDLE;
            endcase
         end
      end
   end

   // Outputs are forced low during the reset cycle, even though state is still stale.
   assign div_start   = !reset && start_q;
   assign div_timeout = !reset && timeout_q;
   assign div_busy    = !reset && (state != DIV_IDLE);
   assign div_stall   = !reset && ((state == DIV_WAIT) || ((state == DIV_IDLE) && start_req));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/bubble/flush scheduler for the 5-stage pipeline
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int DIV_MAX_CYC = 40,
   parameter int CNT_W       = 6
`ifdef HAZARD_PERF_CNT_EN
   ,
   parameter int PERF_W      = 32
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rj,
   input  logic [REG_W-1:0] id_rk,
   input  logic             id_use_rj,
   input  logic             id_use_rk,
   input  logic             id_br_taken,
   input  logic             ex_valid,
   input  logic             ex_res_from_mem,
   input  logic [REG_W-1:0] ex_dest,
   input  logic             ex_is_div,
   input  logic             div_done,
   input  logic             wb_flush,
   output logic             stall_if,
   output logic             stall_id,
   output logic             bubble_ex,
   output logic             stall_ex,
   output logic             flush_if,
   output logic             flush_all,
   output logic             div_start,
   output logic             div_abort,
   output logic             div_busy,
   output logic             div_timeout
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [PERF_W-1:0] perf_lu_cnt,
   output logic [PERF_W-1:0] perf_div_cnt
`endif
);

   logic div_stall_raw;
   logic load_use;
   logic stall_any;

   pipe_div_seq #(
      .DIV_MAX_CYC (DIV_MAX_CYC),
      .CNT_W       (CNT_W)
   ) u_div_seq (
      .clk         (clk),
      .reset       (reset),
      .start_req   (ex_valid && ex_is_div),
      .div_done    (div_done),
      .abort       (wb_flush),
      .div_start   (div_start),
      .div_busy    (div_busy),
      .div_stall   (div_stall_raw),
      .div_timeout (div_timeout)
   );

   // Only a load in EX is uncoverable by forwarding; r0 is never a real dependency.
   assign load_use = !reset && ex_valid && ex_res_from_mem && (ex_dest != ZERO_REG) && id_valid &&
                     (src_hit(id_use_rj, id_rj, ex_dest) || src_hit(id_use_rk, id_rk, ex_dest));

   assign stall_any = (div_stall_raw || load_use) && !wb_flush;

   assign stall_if  = stall_any;
   assign stall_id  = stall_any;
   assign stall_ex  = div_stall_raw && !wb_flush;
   assign bubble_ex = load_use && !div_stall_raw && !wb_flush;
   assign flush_if  = !reset && id_br_taken && id_valid && !stall_any;
   assign flush_all = !reset && wb_flush;
   assign div_abort = wb_flush && div_busy;

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_lu_cnt  <= '0;
         perf_div_cnt <= '0;
      end else begin
         if (bubble_ex)
            perf_lu_cnt <= perf_lu_cnt + 1'b1;
         if (stall_ex)
            perf_div_cnt <= perf_div_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench: vector table, corner sequences, random vs reference model
module tb_pipe_hazard_ctrl;

   localparam int MAX = 40;

   logic clk = 1'b0;
   logic reset, id_valid, id_use_rj, id_use_rk, id_br_taken;
   logic ex_valid, ex_res_from_mem, ex_is_div, div_done, wb_flush;
   logic [4:0] id_rj, id_rk, ex_dest;
   logic stall_if, stall_id, bubble_ex, stall_ex, flush_if, flush_all;
   logic div_start, div_abort, div_busy, div_timeout;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_lu_cnt, perf_div_cnt;
`endif

   int checks = 0;
   int errors = 0;

   pipe_hazard_ctrl #(.DIV_MAX_CYC(MAX), .CNT_W(6)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rj(id_rj), .id_rk(id_rk),
      .id_use_rj(id_use_rj), .id_use_rk(id_use_rk), .id_br_taken(id_br_taken),
      .ex_valid(ex_valid), .ex_res_from_mem(ex_res_from_mem), .ex_dest(ex_dest),
      .ex_is_div(ex_is_div), .div_done(div_done), .wb_flush(wb_flush),
      .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex), .stall_ex(stall_ex),
      .flush_if(flush_if), .flush_all(flush_all), .div_start(div_start), .div_abort(div_abort),
      .div_busy(div_busy), .div_timeout(div_timeout)
`ifdef HAZARD_PERF_CNT_EN
      , .perf_lu_cnt(perf_lu_cnt), .perf_div_cnt(perf_div_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic stall_if, stall_id, bubble_ex, stall_ex, flush_if;
      logic flush_all, div_start, div_abort, div_busy, div_timeout;
   } outs_t;

   typedef struct {
      logic       id_valid;
      logic [4:0] id_rj, id_rk;
      logic       use_rj, use_rk, br;
      logic       ex_valid, ex_mem;
      logic [4:0] ex_dest;
      logic       exp_stall, exp_bubble, exp_flush_if;
   } vec_t;

   // Reference model state: divider activity tracked as "waiting" / "done cycle" plus elapsed wait cycles.
   bit m_waiting, m_done_cyc, m_timeout, m_start;
   int m_wait_cnt;

   outs_t smp;
   int n_stall_ex, n_div_start;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic chkn(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic outs_t model_out();
      outs_t o;
      bit busy, dstall, lu, st;
      busy   = m_waiting || m_done_cyc;
      dstall = m_waiting || (!busy && ex_valid && ex_is_div);
      lu     = ex_valid && ex_res_from_mem && (ex_dest != 5'd0) && id_valid &&
               ((id_use_rj && id_rj == ex_dest) || (id_use_rk && id_rk == ex_dest));
      st     = (dstall || lu) && !wb_flush;
      o.stall_if    = st;
      o.stall_id    = st;
      o.stall_ex    = dstall && !wb_flush;
      o.bubble_ex   = lu && !dstall && !wb_flush;
      o.flush_if    = id_br_taken && id_valid && !st;
      o.flush_all   = wb_flush;
      o.div_start   = m_start;
      o.div_abort   = wb_flush && busy;
      o.div_busy    = busy;
      o.div_timeout = m_timeout;
      if (reset) o = '0;
      return o;
   endfunction

   task automatic model_edge();
      if (reset) begin
         m_waiting = 0; m_done_cyc = 0; m_timeout = 0; m_start = 0; m_wait_cnt = 0;
      end else if (wb_flush) begin
         m_waiting = 0; m_done_cyc = 0; m_start = 0; m_wait_cnt = 0;
      end else if (m_waiting) begin
         m_start = 0;
         if (m_wait_cnt < MAX) m_wait_cnt++;
         if (m_wait_cnt >= MAX) m_timeout = 1;
         if (div_done) begin m_waiting = 0; m_done_cyc = 1; end
      end else if (m_done_cyc) begin
         m_done_cyc = 0; m_start = 0;
      end else begin
         m_start = ex_valid && ex_is_div;
         if (m_start) begin m_waiting = 1; m_wait_cnt = 0; end
      end
   endtask

   task automatic step();
      outs_t e;
      @(negedge clk);
      e = model_out();
      smp = {stall_if, stall_id, bubble_ex, stall_ex, flush_if,
             flush_all, div_start, div_abort, div_busy, div_timeout};
      chk1("stall_if", smp.stall_if, e.stall_if);
      chk1("stall_id", smp.stall_id, e.stall_id);
      chk1("bubble_ex", smp.bubble_ex, e.bubble_ex);
      chk1("stall_ex", smp.stall_ex, e.stall_ex);
      chk1("flush_if", smp.flush_if, e.flush_if);
      chk1("flush_all", smp.flush_all, e.flush_all);
      chk1("div_start", smp.div_start, e.div_start);
      chk1("div_abort", smp.div_abort, e.div_abort);
      chk1("div_busy", smp.div_busy, e.div_busy);
      chk1("div_timeout", smp.div_timeout, e.div_timeout);
      n_stall_ex  += int'(smp.stall_ex);
      n_div_start += int'(smp.div_start);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      id_valid = 0; id_rj = 0; id_rk = 0; id_use_rj = 0; id_use_rk = 0; id_br_taken = 0;
      ex_valid = 0; ex_res_from_mem = 0; ex_dest = 0; ex_is_div = 0; div_done = 0; wb_flush = 0;
   endtask

   vec_t vecs[10];

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 5'd1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 5'd1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1};
      vecs[8] = '{1'b1, 5'd4, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0};
      vecs[9] = '{1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1};

      m_waiting = 0; m_done_cyc = 0; m_timeout = 0; m_start = 0; m_wait_cnt = 0;
      n_stall_ex = 0; n_div_start = 0;
      idle_inputs();
      reset = 1;
      step();
      chk1("reset_outs_zero", |smp, 1'b0);
      step();
      reset = 0;
      step();

      // Combinational load-use / branch vectors, divider idle.
      foreach (vecs[i]) begin
         id_valid = vecs[i].id_valid; id_rj = vecs[i].id_rj; id_rk = vecs[i].id_rk;
         id_use_rj = vecs[i].use_rj; id_use_rk = vecs[i].use_rk; id_br_taken = vecs[i].br;
         ex_valid = vecs[i].ex_valid; ex_res_from_mem = vecs[i].ex_mem; ex_dest = vecs[i].ex_dest;
         step();
         chk1("vec_stall", smp.stall_id, vecs[i].exp_stall);
         chk1("vec_bubble", smp.bubble_ex, vecs[i].exp_bubble);
         chk1("vec_flush_if", smp.flush_if, vecs[i].exp_flush_if);
      end
      idle_inputs();
      step();

      // Branch held by a load-use stall redirects on the release cycle.
      id_valid = 1; id_rj = 5'd7; id_use_rj = 1; id_br_taken = 1;
      ex_valid = 1; ex_res_from_mem = 1; ex_dest = 5'd7;
      step();
      chk1("br_stall_flush_if", smp.flush_if, 1'b0);
      chk1("br_stall_stall_id", smp.stall_id, 1'b1);
      ex_valid = 0;
      step();
      chk1("br_release_flush_if", smp.flush_if, 1'b1);
      chk1("br_release_stall_id", smp.stall_id, 1'b0);
      idle_inputs();
      step();

      // Divide of 8 divider cycles: 9 stall cycles, one start pulse.
      n_stall_ex = 0; n_div_start = 0;
      ex_valid = 1; ex_is_div = 1;
      step();
      for (int w = 1; w <= 8; w++) begin
         div_done = (w == 8);
         step();
      end
      div_done = 0;
      step();
      idle_inputs();
      step();
      chkn("div_stall_cycles", n_stall_ex, 9);
      chkn("div_start_pulses", n_div_start, 1);
      chk1("div_busy_after", div_busy, 1'b0);

      // Flush in the third WAIT cycle aborts the divide; a stray div_done is ignored.
      ex_valid = 1; ex_is_div = 1;
      step(); step(); step();
      wb_flush = 1;
      step();
      chk1("flush_div_abort", smp.div_abort, 1'b1);
      chk1("flush_flush_all", smp.flush_all, 1'b1);
      chk1("flush_stall_ex", smp.stall_ex, 1'b0);
      chk1("flush_stall_id", smp.stall_id, 1'b0);
      idle_inputs();
      step();
      chk1("flush_idle_busy", smp.div_busy, 1'b0);
      div_done = 1;
      step();
      div_done = 0;
      step();
      chk1("stray_done_busy", smp.div_busy, 1'b0);
      chk1("stray_done_stall", smp.stall_ex, 1'b0);

      // Timeout: no div_done for 40 WAIT cycles.
      ex_valid = 1; ex_is_div = 1;
      step();
      for (int k = 1; k <= MAX; k++) begin
         step();
         if (k == MAX - 1) chk1("timeout_not_yet", div_timeout, 1'b0);
      end
      chk1("timeout_set", div_timeout, 1'b1);
      repeat (5) step();
      chk1("timeout_sticky", div_timeout, 1'b1);
      wb_flush = 1;
      step();
      idle_inputs();
      step();
      chk1("timeout_kept_after_flush", div_timeout, 1'b1);
      chk1("timeout_busy_cleared", div_busy, 1'b0);

      // Reset in the middle of a divide, then a clean restart.
      ex_valid = 1; ex_is_div = 1;
      step(); step(); step();
      reset = 1;
      step();
      chk1("rst_mid_outs_zero", |smp, 1'b0);
      reset = 0;
      n_div_start = 0;
      step();
      step(); step();
      div_done = 1;
      step();
      div_done = 0;
      step();
      idle_inputs();
      step();
      chkn("restart_start_pulses", n_div_start, 1);
      chk1("restart_timeout_clear", div_timeout, 1'b0);
      chk1("restart_busy", div_busy, 1'b0);

      // Random traffic checked cycle by cycle against the model.
      for (int r = 0; r < 3000; r++) begin
         reset           = ($urandom_range(0, 299) == 0);
         wb_flush        = ($urandom_range(0, 24) == 0);
         id_valid        = 1'($urandom_range(0, 1));
         id_rj           = 5'($urandom_range(0, 3));
         id_rk           = 5'($urandom_range(0, 3));
         id_use_rj       = 1'($urandom_range(0, 1));
         id_use_rk       = 1'($urandom_range(0, 1));
         id_br_taken     = ($urandom_range(0, 3) == 0);
         ex_valid        = 1'($urandom_range(0, 1));
         ex_res_from_mem = 1'($urandom_range(0, 1));
         ex_dest         = 5'($urandom_range(0, 3));
         ex_is_div       = ($urandom_range(0, 7) == 0);
         div_done        = ($urandom_range(0, 5) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
